pht_counter_table: RTL and testbench
====================================

Name: pht_counter_table

Overview:
- Parametrised pattern history table: 2^INDEX_W saturating counters of CNT_W bits each, with one lookup port and one update port.
- Generalises the single 2-bit taken/not-taken FSM to a table of configurable counter width and depth.
- Optional global-history (gshare) indexing.
- Sits in the fetch stage: the front end issues lookups, and the branch resolution unit in execute returns outcomes on the update port.

Parameters:
- PC_W, 32, lookup PC width.
- INDEX_W, 6, table index width; ENTRIES = 2^INDEX_W.
- CNT_W, 2, saturating counter width (>= 2).
- GHR_W, INDEX_W, global history register width (<= INDEX_W).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- lookup_valid  in  1  lookup request this cycle.
- lookup_pc  in  PC_W  branch PC; index taken from lookup_pc[INDEX_W+1:2].
- pred_valid  out  1  registered prediction valid.
- pred_taken  out  1  predicted direction (counter MSB).
- pred_state  out  CNT_W  counter value used for the prediction.
- pred_index  out  INDEX_W  table index used; carried down the pipe and returned on update_index.
- update_valid  in  1  resolved branch outcome this cycle.
- update_index  in  INDEX_W  entry to train.
- update_taken  in  1  resolved direction.
- ghr  out  GHR_W  current global history (all zeros when the feature is off).

Behaviour:
- Reset (async assert, applies immediately):
  - every counter = 2^CNT_W-1 (strongly taken);
  - pred_valid=0, pred_taken=0, pred_state=0, pred_index=0, ghr=0.
  - Reset asserted mid-lookup or mid-update discards that request; the first edge after deassert behaves as a normal cycle.
- Lookup index: idx = lookup_pc[INDEX_W+1:2], XORed with the history when GSHARE_EN is defined.
- Latency: 1 cycle. At the clk edge with lookup_valid=1, the pred_* registers load:
  - pred_valid=1;
  - pred_state = counter[idx];
  - pred_taken = MSB of pred_state;
  - pred_index = idx.
- With lookup_valid=0, pred_valid<=0 and the other pred_* outputs hold their values.
- Counter update at the edge with update_valid=1:
  - update_taken=1: counter increments, saturating at 2^CNT_W-1.
  - update_taken=0: counter decrements, saturating at 0.
  - No wrap-around in either direction.
  - With CNT_W=2, the states map to 11 strongly taken, 10 weakly taken, 01 weakly not taken, 00 strongly not taken.
- Same-cycle lookup and update to the same index: the prediction reflects the post-update value (write-through bypass). Different indices: fully independent.
- Out-of-range update_index: not possible, because the table is a full power of two.
- Only one update per cycle. No backpressure: the block always accepts both ports, with no ready signals.
- History, only when GSHARE_EN is defined:
  - on update_valid, ghr <= {ghr[GHR_W-2:0], update_taken};
  - lookups in the same cycle use the pre-shift ghr.

Optional Feature:
- Macro: PHT_GSHARE_EN.
- Defined:
  - lookup idx = lookup_pc[INDEX_W+1:2] XOR zero-extended ghr;
  - ghr shifts as described under Behaviour.
- Undefined:
  - no history register is built; ghr is tied to 0;
  - idx = lookup_pc[INDEX_W+1:2];
  - update behaviour is otherwise identical.

Test Plan:
- Reset defaults: assert reset, then look up PC 0x0000_0010 -> next cycle pred_valid=1, pred_state=2'b11, pred_taken=1, pred_index=4.
- Training down: three updates, taken=0, to index 4, then lookup of PC 0x10 -> pred_state=00, pred_taken=0. A fourth not-taken update leaves the counter at 00 (saturates, no wrap).
- Training up and bypass: counter at 00, then update taken=1 to index 4 in the same cycle as a lookup of PC 0x10 -> pred_state=01. The next taken update plus lookup -> 10, pred_taken=1.
- Independence: update index 5 not-taken while looking up index 4 -> index 4 prediction unchanged at its previous value; index 5 reads 10.
- Mid-operation reset: train index 7 to 00, assert reset asynchronously between edges -> pred_valid drops immediately; after deassert, a lookup of PC 0x1C returns 11.
- gshare (PHT_GSHARE_EN defined): updates taken, taken, not-taken -> ghr=6'b000110. A lookup of PC 0x10 then uses idx 4^6 = 2, giving pred_index=2.

Source files
------------

// File: rtl/pht_counter_table.sv
// pht_counter_table -- pattern history table of saturating direction counters.
//
// 2^INDEX_W counters of CNT_W bits, one lookup port and one update port.
// The lookup is registered, so the prediction appears one cycle after the request.
// An update trains one counter per cycle.
// When an update and a lookup hit the same entry in the same cycle, the
// prediction returns the post-update value.
//
// Optional feature: define PHT_GSHARE_EN to build a global history register.
// The history is XORed into the lookup index (gshare).
// With the macro undefined, no history is built and ghr is tied to 0.
//
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   lookup_valid/pc     lookup request; index = lookup_pc[INDEX_W+1:2] (^ ghr)
//   pred_valid/taken/   registered prediction: counter value, its MSB, and
//   pred_state/index    the table index used
//   update_valid/index/ resolved branch outcome used to train one counter
//   update_taken
//   ghr                 current global history (0 when the feature is off)

// One table entry: saturating up/down counter, reset to strongly taken.
// cnt_next is exposed so that a same-cycle read sees the trained value.
module pht_counter_cell #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             upd,
  input  logic             taken,
  output logic [CNT_W-1:0] cnt_next
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (upd) begin
      if (taken) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= CNT_MAX;
    else       cnt_q <= cnt_d;
  end

  assign cnt_next = cnt_d;
endmodule

module pht_counter_table #(
  parameter int PC_W    = 32,
  parameter int INDEX_W = 6,
  parameter int CNT_W   = 2,
  parameter int GHR_W   = INDEX_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lookup_valid,
  input  logic [PC_W-1:0]    lookup_pc,
  output logic               pred_valid,
  output logic               pred_taken,
  output logic [CNT_W-1:0]   pred_state,
  output logic [INDEX_W-1:0] pred_index,
  input  logic               update_valid,
  input  logic [INDEX_W-1:0] update_index,
  input  logic               update_taken,
  output logic [GHR_W-1:0]   ghr
);
  localparam int ENTRIES = 1 << INDEX_W;

  logic [ENTRIES-1:0][CNT_W-1:0] cnt_next;
  logic [ENTRIES-1:0]            upd_hit;
  logic [INDEX_W-1:0]            pc_idx, lookup_idx;

  logic               pred_valid_q, pred_valid_d;
  logic [CNT_W-1:0]   pred_state_q, pred_state_d;
  logic [INDEX_W-1:0] pred_index_q, pred_index_d;

  // Only the word-aligned index bits of the PC feed the table.
  logic unused_pc;
  assign unused_pc = ^{lookup_pc[PC_W-1:INDEX_W+2], lookup_pc[1:0]};
  assign pc_idx    = lookup_pc[INDEX_W+1:2];

  always_comb begin
    upd_hit = '0;
    if (update_valid) upd_hit[update_index] = 1'b1;
  end

  for (genvar e = 0; e < ENTRIES; e++) begin : g_cell
    pht_counter_cell #(.CNT_W(CNT_W)) u_cell (
      .clk      (clk),
      .reset    (reset),
      .upd      (upd_hit[e]),
      .taken    (update_taken),
      .cnt_next (cnt_next[e])
    );
  end

`ifdef PHT_GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;

  // The shift lands at the edge, so same-cycle lookups hash with the old history.
  always_comb begin
    ghr_d = ghr_q;
    if (update_valid) ghr_d = (ghr_q << 1) | GHR_W'(update_taken);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end

  assign ghr        = ghr_q;
  assign lookup_idx = pc_idx ^ INDEX_W'(ghr_q);
`else
  assign ghr        = '0;
  assign lookup_idx = pc_idx;
`endif

  // cnt_next equals the stored value unless that entry is trained this
  // cycle, so reading it gives the write-through bypass for free.
  always_comb begin
    pred_valid_d = lookup_valid;
    pred_state_d = pred_state_q;
    pred_index_d = pred_index_q;
    if (lookup_valid) begin
      pred_state_d = cnt_next[lookup_idx];
      pred_index_d = lookup_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_valid_q <= 1'b0;
      pred_state_q <= '0;
      pred_index_q <= '0;
    end else begin
      pred_valid_q <= pred_valid_d;
      pred_state_q <= pred_state_d;
      pred_index_q <= pred_index_d;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_state = pred_state_q;
  assign pred_taken = pred_state_q[CNT_W-1];
  assign pred_index = pred_index_q;
endmodule

// File: tb/tb_pht_counter_table.sv
module tb_pht_counter_table;
  localparam int PC_W    = 32;
  localparam int INDEX_W = 6;
  localparam int CNT_W   = 2;
  localparam int GHR_W   = INDEX_W;
  localparam int ENTRIES = 1 << INDEX_W;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               lookup_valid;
  logic [PC_W-1:0]    lookup_pc;
  logic               pred_valid, pred_taken;
  logic [CNT_W-1:0]   pred_state;
  logic [INDEX_W-1:0] pred_index;
  logic               update_valid;
  logic [INDEX_W-1:0] update_index;
  logic               update_taken;
  logic [GHR_W-1:0]   ghr;

  pht_counter_table #(.PC_W(PC_W), .INDEX_W(INDEX_W), .CNT_W(CNT_W), .GHR_W(GHR_W)) dut (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_state(pred_state), .pred_index(pred_index),
    .update_valid(update_valid), .update_index(update_index),
    .update_taken(update_taken), .ghr(ghr)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int state; } exp_t;
  exp_t q[$];
  int   m_cnt[ENTRIES];
  int   m_ghr;
  int   last_state, last_idx;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_cnt[i] = CMAX;
    m_ghr = 0;
    q.delete();
    last_state = 0;
    last_idx   = 0;
  endtask

  // One clock cycle of stimulus; the model is advanced at the edge that
  // samples these inputs.
  task automatic cyc(input bit lv, input logic [PC_W-1:0] pc,
                     input bit uv, input int ui, input bit ut);
    int idx;
    lookup_valid = lv; lookup_pc = pc;
    update_valid = uv; update_index = INDEX_W'(ui); update_taken = ut;
    @(posedge clk);
    idx = int'((pc >> 2) & (ENTRIES - 1));
`ifdef PHT_GSHARE_EN
    idx = idx ^ m_ghr;
`endif
    if (uv) begin
      if (ut) m_cnt[ui] = (m_cnt[ui] == CMAX) ? CMAX : m_cnt[ui] + 1;
      else    m_cnt[ui] = (m_cnt[ui] == 0)    ? 0    : m_cnt[ui] - 1;
`ifdef PHT_GSHARE_EN
      m_ghr = ((m_ghr << 1) | int'(ut)) & ((1 << GHR_W) - 1);
`endif
    end
    if (lv) q.push_back('{idx, m_cnt[idx]});
    #1;
  endtask

  task automatic idle(); cyc(0, '0, 0, 0, 0); endtask

  // Async reset between edges with both ports active; those requests must vanish.
  task automatic mid_reset();
    #2;
    reset = 1'b1; lookup_valid = 1'b1; update_valid = 1'b1;
    #1;
    chk("async_rst_pred_valid", int'(pred_valid), 0);
    chk("async_rst_ghr", int'(ghr), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    lookup_valid = 1'b0; update_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: after every edge, a prediction must be present exactly when the
  // scoreboard holds one, and all outputs must match the expected/held values.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #2;
      chk("pred_valid", int'(pred_valid), int'(q.size() > 0));
      if (q.size() > 0) begin
        e = q.pop_front();
        last_state = e.state;
        last_idx   = e.idx;
      end
      chk("pred_state", int'(pred_state), last_state);
      chk("pred_taken", int'(pred_taken), int'(last_state >= (1 << (CNT_W - 1))));
      chk("pred_index", int'(pred_index), last_idx);
      chk("ghr", int'(ghr), m_ghr);
    end
  end

  initial begin
    logic [PC_W-1:0] pc;
    int ui;
    reset = 1'b1;
    lookup_valid = 1'b0; lookup_pc = '0;
    update_valid = 1'b0; update_index = '0; update_taken = 1'b0;
    model_reset();
    #1;
    chk("rst_pred_valid", int'(pred_valid), 0);
    chk("rst_pred_state", int'(pred_state), 0);
    chk("rst_pred_index", int'(pred_index), 0);
    chk("rst_ghr", int'(ghr), 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Reset defaults.
    cyc(1, 32'h10, 0, 0, 0);
    chk("dflt_state", int'(pred_state), CMAX);
    chk("dflt_index", int'(pred_index), 4);
    chk("dflt_taken", int'(pred_taken), 1);
    // Train down to 0, check, then saturate.
    repeat (3) cyc(0, '0, 1, 4, 0);
    cyc(1, 32'h10, 0, 0, 0);
    cyc(0, '0, 1, 4, 0);
    cyc(1, 32'h10, 0, 0, 0);
    // Train up with same-cycle lookup (bypass).
    cyc(1, 32'h10, 1, 4, 1);
    cyc(1, 32'h10, 1, 4, 1);
    // Independence: update index 5 while looking up index 4, then read 5.
    cyc(1, 32'h10, 1, 5, 0);
    cyc(1, 32'h14, 0, 0, 0);
    // Mid-operation reset.
    repeat (3) cyc(0, '0, 1, 7, 0);
    cyc(1, 32'h1C, 0, 0, 0);
    mid_reset();
    cyc(1, 32'h1C, 0, 0, 0);
    chk("post_rst_state", int'(pred_state), CMAX);
    // History sequence T, T, NT then a lookup.
    cyc(0, '0, 1, 1, 1);
    cyc(0, '0, 1, 1, 1);
    cyc(0, '0, 1, 1, 0);
`ifdef PHT_GSHARE_EN
    chk("ghr_seq", int'(ghr), 6);
`endif
    cyc(1, 32'h10, 0, 0, 0);
`ifdef PHT_GSHARE_EN
    chk("gshare_index", int'(pred_index), 2);
`else
    chk("plain_index", int'(pred_index), 4);
`endif

    // Randomized traffic, biased toward a few entries so bypass and
    // saturation are hit often.
    for (int i = 0; i < 1500; i++) begin
      pc = $urandom;
      if ($urandom_range(0, 1) == 1) pc[INDEX_W+1:2] = INDEX_W'($urandom_range(0, 7));
      ui = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, ENTRIES - 1));
      cyc($urandom_range(0, 3) != 0, pc, $urandom_range(0, 2) != 0, ui, $urandom_range(0, 1) == 1);
      if (i == 700) mid_reset();
    end
    repeat (3) idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
